pipeline_stage_regs: RTL and testbench

Holds the inter-stage state of the 5-stage MIPS pipeline: PC, and the instruction word and PC+8 for the D, E, M and W stages. It produces the InsD/InsE/InsM/InsW words that the hazard/forwarding control reads, and it acts on that control's stall output. On a stall it freezes the fetch side and inserts a bubble into E. It also keeps cycle, stall and retire counters for performance checks.

---
 rtl/pipeline_stage_regs.sv | 118 +++++++++++
 tb/tb_pipeline_stage_regs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_regs.sv
// ---------------------------------------------------------------------------
// pipeline_stage_regs
//
// Inter-stage state of the 5-stage MIPS pipeline: the fetch PC plus the
// instruction word and PC+8 for the D, E, M and W stages. It also keeps
// saturating cycle, stall and retire counters.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset      - asynchronous, active-high, clears all state immediately
//   stall      - from hazard control, sampled at the rising edge
//   NPC        - next PC; the low two bits are dropped
//   InstrF     - instruction word read at PCF
//   PCF        - current fetch PC
//   InsD/E/M/W - instruction word held in each stage (0 = bubble)
//   PC8D/E/M/W - PC+8 of the instruction held in each stage
//   cycle_cnt  - edges since reset
//   stall_cnt  - edges on which stall was 1
//   retire_cnt - non-bubble instructions that entered W
//
// Stall semantics: stall is a level that the hazard control holds for each
// edge it wants frozen. On an edge with stall=1 the F/D side (PCF, InsD,
// PC8D) holds and a bubble (all-zero word, PC8 = 0) enters E, while M and W
// keep shifting so older instructions drain. There is no valid/ready
// handshake: every edge either advances or stalls.
//
// All outputs are direct register outputs, so no combinational path exists
// from stall, NPC or InstrF to any output.
// ---------------------------------------------------------------------------
module pipeline_stage_regs #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      NPC,
    input  logic [31:0]      InstrF,
    output logic [31:0]      PCF,
    output logic [31:0]      InsD,
    output logic [31:0]      InsE,
    output logic [31:0]      InsM,
    output logic [31:0]      InsW,
    output logic [31:0]      PC8D,
    output logic [31:0]      PC8E,
    output logic [31:0]      PC8M,
    output logic [31:0]      PC8W,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Fetch side and decode stage: frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF  <= PC_INIT;
            InsD <= 32'd0;
            PC8D <= 32'd0;
        end else if (!stall) begin
            PCF  <= {NPC[31:2], 2'b00};
            InsD <= InstrF;
            PC8D <= PCF + 32'd8;
        end
    end

    // Execute stage: takes D normally, takes a bubble while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InsE <= 32'd0;
            PC8E <= 32'd0;
        end else if (stall) begin
            InsE <= 32'd0;
            PC8E <= 32'd0;
        end else begin
            InsE <= InsD;
            PC8E <= PC8D;
        end
    end

    // Memory and writeback stages always shift so older work drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InsM <= 32'd0;
            PC8M <= 32'd0;
            InsW <= 32'd0;
            PC8W <= 32'd0;
        end else begin
            InsM <= InsE;
            PC8M <= PC8E;
            InsW <= InsM;
            PC8W <= PC8M;
        end
    end

    // Performance counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            // A zero word in M is a bubble; only real instructions retire.
            if ((InsM != 32'd0) && (retire_cnt != CNT_MAX)) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_regs
//
// Bench for pipeline_stage_regs. A reference model of the pipeline tracks
// expected stage contents; the word leaving M on each edge is pushed to a
// queue before the edge and popped and compared against W after it. A
// second instance with CNT_W=4 covers counter saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_regs;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] NPC;
    logic [31:0] InstrF;

    logic [31:0] PCF, InsD, InsE, InsM, InsW, PC8D, PC8E, PC8M, PC8W;
    logic [31:0] cycle_cnt, stall_cnt, retire_cnt;

    logic [31:0] sPCF, sInsD, sInsE, sInsM, sInsW, sPC8D, sPC8E, sPC8M, sPC8W;
    logic [3:0]  sCyc, sStl, sRet;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mPC, mInsD, mInsE, mInsM, mInsW, mPc8D, mPc8E, mPc8M, mPc8W;
    logic [31:0] mCyc, mStl, mRet;
    logic [63:0] exp_q[$];

    pipeline_stage_regs dut (
        .clk(clk), .reset(reset), .stall(stall), .NPC(NPC), .InstrF(InstrF),
        .PCF(PCF), .InsD(InsD), .InsE(InsE), .InsM(InsM), .InsW(InsW),
        .PC8D(PC8D), .PC8E(PC8E), .PC8M(PC8M), .PC8W(PC8W),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    pipeline_stage_regs #(.CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .stall(stall), .NPC(NPC), .InstrF(InstrF),
        .PCF(sPCF), .InsD(sInsD), .InsE(sInsE), .InsM(sInsM), .InsW(sInsW),
        .PC8D(sPC8D), .PC8E(sPC8E), .PC8M(sPC8M), .PC8W(sPC8W),
        .cycle_cnt(sCyc), .stall_cnt(sStl), .retire_cnt(sRet)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic modelReset();
        mPC = 32'h0000_3000;
        {mInsD, mInsE, mInsM, mInsW} = '0;
        {mPc8D, mPc8E, mPc8M, mPc8W} = '0;
        {mCyc, mStl, mRet} = '0;
        exp_q.delete();
    endtask

    // Called between edges; pulses reset without any clock edge in between.
    task automatic applyReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    // Driver: one edge with the given inputs, followed by full comparison.
    task automatic driveEdge(input logic st, input logic [31:0] npc, input logic [31:0] instr);
        logic [63:0] expW;
        stall  = st;
        NPC    = npc;
        InstrF = instr;
        exp_q.push_back({mInsM, mPc8M});
        if (mInsM != 32'd0) mRet = sat32(mRet);
        mInsW = mInsM; mPc8W = mPc8M;
        mInsM = mInsE; mPc8M = mPc8E;
        if (st) begin
            mInsE = 32'd0; mPc8E = 32'd0;
            mStl  = sat32(mStl);
        end else begin
            mInsE = mInsD; mPc8E = mPc8D;
            mInsD = instr; mPc8D = mPC + 32'd8;
            mPC   = {npc[31:2], 2'b00};
        end
        mCyc = sat32(mCyc);
        @(posedge clk);
        #1;
        expW = exp_q.pop_front();
        checks++;
        if ({InsW, PC8W} !== expW) begin
            errors++;
            $display("FAIL wstage: got InsW=%h PC8W=%h expected %h/%h", InsW, PC8W, expW[63:32], expW[31:0]);
        end
        checks++;
        if ({PCF, InsD, PC8D} !== {mPC, mInsD, mPc8D}) begin
            errors++;
            $display("FAIL fdstage: got PCF=%h InsD=%h PC8D=%h expected %h/%h/%h", PCF, InsD, PC8D, mPC, mInsD, mPc8D);
        end
        checks++;
        if ({InsE, PC8E, InsM, PC8M} !== {mInsE, mPc8E, mInsM, mPc8M}) begin
            errors++;
            $display("FAIL emstage: got InsE=%h PC8E=%h InsM=%h PC8M=%h expected %h/%h/%h/%h",
                     InsE, PC8E, InsM, PC8M, mInsE, mPc8E, mInsM, mPc8M);
        end
        checks++;
        if ({cycle_cnt, stall_cnt, retire_cnt} !== {mCyc, mStl, mRet}) begin
            errors++;
            $display("FAIL counters: got cyc=%0d stl=%0d ret=%0d expected %0d/%0d/%0d",
                     cycle_cnt, stall_cnt, retire_cnt, mCyc, mStl, mRet);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (PCF !== 32'h0000_3000) begin
            errors++; $display("FAIL reset_pcf: got %h expected 00003000", PCF);
        end
        checks++;
        if ({InsD, InsE, InsM, InsW} !== 128'd0) begin
            errors++; $display("FAIL reset_ins: got %h %h %h %h expected all 0", InsD, InsE, InsM, InsW);
        end
        checks++;
        if ({PC8D, PC8E, PC8M, PC8W} !== 128'd0) begin
            errors++; $display("FAIL reset_pc8: got %h %h %h %h expected all 0", PC8D, PC8E, PC8M, PC8W);
        end
        checks++;
        if ({cycle_cnt, stall_cnt, retire_cnt, sCyc, sStl, sRet} !== 108'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d %0d %0d %0d %0d expected all 0",
                               cycle_cnt, stall_cnt, retire_cnt, sCyc, sStl, sRet);
        end
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_straight_line();
        applyReset();
        driveEdge(1'b0, mPC + 32'd4, 32'h3C01_1234);
        checks++;
        if ({InsD, PC8D} !== {32'h3C01_1234, 32'h0000_3008}) begin
            errors++; $display("FAIL straight_d: got %h/%h expected 3c011234/00003008", InsD, PC8D);
        end
        for (int i = 0; i < 3; i++) driveEdge(1'b0, mPC + 32'd4, 32'd0);
        checks++;
        if ({InsW, PC8W, retire_cnt} !== {32'h3C01_1234, 32'h0000_3008, 32'd1}) begin
            errors++; $display("FAIL straight_w: got %h/%h ret=%0d expected 3c011234/00003008 ret=1", InsW, PC8W, retire_cnt);
        end
    endtask

    task automatic test_single_stall();
        logic [31:0] pcHeld;
        applyReset();
        driveEdge(1'b0, mPC + 32'd4, 32'h2401_0005);
        driveEdge(1'b0, mPC + 32'd4, 32'h1022_0003);
        pcHeld = mPC;
        driveEdge(1'b1, mPC + 32'd4, 32'h0000_0BAD);
        checks++;
        if ({PCF, InsD, InsE, PC8E, InsM, stall_cnt} !==
            {pcHeld, 32'h1022_0003, 32'd0, 32'd0, 32'h2401_0005, 32'd1}) begin
            errors++; $display("FAIL single_stall: got PCF=%h D=%h E=%h PC8E=%h M=%h stl=%0d expected %h/10220003/0/0/24010005/1",
                               PCF, InsD, InsE, PC8E, InsM, stall_cnt, pcHeld);
        end
        driveEdge(1'b0, mPC + 32'd4, 32'd0);
        checks++;
        if (InsE !== 32'h1022_0003) begin
            errors++; $display("FAIL single_release: got InsE=%h expected 10220003", InsE);
        end
    endtask

    task automatic test_back_to_back_stall();
        applyReset();
        driveEdge(1'b0, mPC + 32'd4, 32'h8C22_0004);
        driveEdge(1'b0, mPC + 32'd4, 32'h0041_1820);
        for (int i = 0; i < 2; i++) begin
            driveEdge(1'b1, mPC + 32'd4, 32'h0000_0BAD);
            checks++;
            if ({InsD, InsE} !== {32'h0041_1820, 32'd0}) begin
                errors++; $display("FAIL double_hold%0d: got D=%h E=%h expected 00411820/0", i, InsD, InsE);
            end
        end
        checks++;
        if ({InsM, InsW, stall_cnt} !== {32'd0, 32'h8C22_0004, 32'd2}) begin
            errors++; $display("FAIL double_stall: got M=%h W=%h stl=%0d expected 0/8c220004/2", InsM, InsW, stall_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            driveEdge(1'b0, mPC + 32'd4, 32'd0);
            checks++;
            if (InsW !== 32'd0) begin
                errors++; $display("FAIL double_bubble%0d: got InsW=%h expected 0", i, InsW);
            end
        end
        driveEdge(1'b0, mPC + 32'd4, 32'd0);
        checks++;
        if ({InsW, retire_cnt} !== {32'h0041_1820, 32'd2}) begin
            errors++; $display("FAIL double_retire: got W=%h ret=%0d expected 00411820/2", InsW, retire_cnt);
        end
    endtask

    task automatic test_misaligned_npc();
        applyReset();
        driveEdge(1'b0, 32'h0000_3017, 32'h0000_0001);
        checks++;
        if (PCF !== 32'h0000_3014) begin
            errors++; $display("FAIL misaligned: got PCF=%h expected 00003014", PCF);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        for (int i = 0; i < 15; i++) driveEdge(1'b1, mPC + 32'd4, 32'd0);
        checks++;
        if ({sCyc, sStl} !== {4'd15, 4'd15}) begin
            errors++; $display("FAIL sat_reach: got cyc=%0d stl=%0d expected 15/15", sCyc, sStl);
        end
        for (int i = 0; i < 5; i++) driveEdge(1'b1, mPC + 32'd4, 32'd0);
        checks++;
        if ({sCyc, sStl, sRet} !== {4'd15, 4'd15, 4'd0}) begin
            errors++; $display("FAIL sat_hold: got cyc=%0d stl=%0d ret=%0d expected 15/15/0", sCyc, sStl, sRet);
        end
    endtask

    task automatic test_mid_reset();
        applyReset();
        for (int i = 0; i < 5; i++) driveEdge(1'b0, mPC + 32'd4, $urandom | 32'h1);
        reset = 1'b1;
        #1;
        checks++;
        if ({PCF, InsD, InsE, InsM, InsW, PC8D, PC8E, PC8M, PC8W, cycle_cnt, stall_cnt, retire_cnt}
            !== {32'h0000_3000, 352'd0}) begin
            errors++; $display("FAIL mid_reset: got PCF=%h D=%h E=%h M=%h W=%h PC8W=%h cyc=%0d ret=%0d expected 00003000 and all 0",
                               PCF, InsD, InsE, InsM, InsW, PC8W, cycle_cnt, retire_cnt);
        end
        #1;
        reset = 1'b0;
        modelReset();
        driveEdge(1'b0, mPC + 32'd4, 32'h3C02_ABCD);
        checks++;
        if ({InsD, PC8D, PCF} !== {32'h3C02_ABCD, 32'h0000_3008, 32'h0000_3004}) begin
            errors++; $display("FAIL mid_restart: got D=%h PC8D=%h PCF=%h expected 3c02abcd/00003008/00003004", InsD, PC8D, PCF);
        end
    endtask

    task automatic test_random();
        applyReset();
        for (int i = 0; i < 300; i++) begin
            driveEdge($urandom_range(0, 3) == 0,
                      ($urandom_range(0, 4) == 0) ? $urandom : mPC + 32'd4,
                      ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);
        end
    endtask

    initial begin
        reset  = 1'b0;
        stall  = 1'b0;
        NPC    = 32'd0;
        InstrF = 32'd0;
        test_reset();
        test_straight_line();
        test_single_stall();
        test_back_to_back_stall();
        test_misaligned_npc();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
